// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decode-stage immediate generator with a DEPTH-entry output buffer.
//   The immediate is built combinationally from Instr/ImmSrc and captured
//   together with InTag and an error flag on every accepted push.
//   Both sides use valid/ready handshakes; InReady depends on registered
//   state only, so there is no combinational path from OutReady.
//   Optional feature macro: IMM_EXTEND_RVC_EN (compressed CI/CJ formats
//   on ImmSrc 110/111). Without it those codes are flagged via ImmErr.
module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [31:0]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic [TAG_W-1:0] InTag,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [XLEN-1:0]  ImmExt,
   output logic [TAG_W-1:0] OutTag,
   output logic             ImmErr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [63:0]      ext64;
   logic [XLEN-1:0]  imm_c;
   logic             err_c;

   logic [XLEN-1:0]  mem_imm [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic             mem_err [DEPTH];

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic             push;
   logic             pop;

   // Build the 64-bit sign/zero-extended immediate, then keep the low XLEN bits.
   // U-type carries the sign into the upper half only when XLEN is 64.
   always_comb begin
      ext64 = '0;
      err_c = 1'b0;
      case (ImmSrc)
         3'b000: ext64 = {{52{Instr[31]}}, Instr[31:20]};
         3'b001: ext64 = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
         3'b010: ext64 = {{51{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
         3'b011: ext64 = {{32{Instr[31]}}, Instr[31:12], 12'b0};
         3'b100: ext64 = {{43{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
         3'b101: ext64 = {59'b0, Instr[19:15]};
`ifdef IMM_EXTEND_RVC_EN
         3'b110: ext64 = {{58{Instr[12]}}, Instr[12], Instr[6:2]};
         3'b111: ext64 = {{52{Instr[12]}}, Instr[12], Instr[8], Instr[10:9],
                          Instr[6], Instr[7], Instr[2], Instr[11], Instr[5:3], 1'b0};
`endif
         default: begin
            ext64 = '0;
            err_c = 1'b1;
         end
      endcase
      imm_c = ext64[XLEN-1:0];
   end

   assign InReady  = (count != FULL_CNT);
   assign OutValid = (count != '0);
   assign push     = InValid & InReady & ~Flush;
   assign pop      = OutValid & OutReady;

   // Capture the extended immediate, tag and error flag at the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wr_ptr] <= imm_c;
         mem_tag[wr_ptr] <= InTag;
         mem_err[wr_ptr] <= err_c;
      end
   end

   // Pointer and occupancy bookkeeping; Flush overrides any push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Head entry is presented only while valid; stored contents are masked otherwise.
   always_comb begin
      ImmExt = '0;
      OutTag = '0;
      ImmErr = 1'b0;
      if (OutValid) begin
         ImmExt = mem_imm[rd_ptr];
         OutTag = mem_tag[rd_ptr];
         ImmErr = mem_err[rd_ptr];
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe (XLEN=32 main instance, XLEN=64
//   companion instance sharing the same inputs). Expected values are
//   hand-computed constants.
module tb_imm_extend_pipe;

   logic        clk;
   logic        reset;
   logic        Flush;
   logic        InValid;
   logic        InReady;
   logic [31:0] Instr;
   logic [2:0]  ImmSrc;
   logic [7:0]  InTag;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] ImmExt;
   logic [7:0]  OutTag;
   logic        ImmErr;

   logic        in_ready64;
   logic        out_valid64;
   logic [63:0] imm_ext64;
   logic [7:0]  out_tag64;
   logic        imm_err64;

   int n_checks;
   int n_errors;

   imm_extend_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(8)) dut (
      .clk(clk), .reset(reset), .Flush(Flush),
      .InValid(InValid), .InReady(InReady),
      .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
      .OutValid(OutValid), .OutReady(OutReady),
      .ImmExt(ImmExt), .OutTag(OutTag), .ImmErr(ImmErr)
   );

   imm_extend_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(8)) dut64 (
      .clk(clk), .reset(reset), .Flush(Flush),
      .InValid(InValid), .InReady(in_ready64),
      .Instr(Instr), .ImmSrc(ImmSrc), .InTag(InTag),
      .OutValid(out_valid64), .OutReady(OutReady),
      .ImmExt(imm_ext64), .OutTag(out_tag64), .ImmErr(imm_err64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one item for a single cycle with OutReady low, then idle the input.
   task automatic push_one(input logic [2:0] src, input logic [31:0] ins, input logic [7:0] tg);
      ImmSrc  = src;
      Instr   = ins;
      InTag   = tg;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      Instr   = 32'hDEAD_BEEF;
      InTag   = 8'hEE;
   endtask

   task automatic pop_one();
      OutReady = 1'b1;
      step();
      OutReady = 1'b0;
   endtask

   // Push, check head one cycle later, pop, check empty.
   task automatic run_vec(input string nm, input logic [2:0] src, input logic [31:0] ins,
                          input logic [7:0] tg, input logic [31:0] exp_imm, input logic exp_err);
      push_one(src, ins, tg);
      chk({nm, "_valid"}, 64'(OutValid), 64'(1'b1));
      chk({nm, "_imm"},   64'(ImmExt),   64'(exp_imm));
      chk({nm, "_err"},   64'(ImmErr),   64'(exp_err));
      chk({nm, "_tag"},   64'(OutTag),   64'(tg));
      pop_one();
      chk({nm, "_empty"}, 64'(OutValid), 64'(1'b0));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      Flush    = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b0;
      Instr    = '0;
      ImmSrc   = '0;
      InTag    = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_outvalid", 64'(OutValid), 64'(1'b0));
      chk("rst_inready",  64'(InReady),  64'(1'b1));
      chk("rst_imm",      64'(ImmExt),   64'(32'h0));
      chk("rst_tag",      64'(OutTag),   64'(8'h0));
      step();

      // Formats
      run_vec("i_neg", 3'b000, 32'hFFF00093, 8'h05, 32'hFFFFFFFF, 1'b0);
      run_vec("i_pos", 3'b000, 32'h7FF00000, 8'h06, 32'h000007FF, 1'b0);
      run_vec("s_neg", 3'b001, 32'h80000080, 8'h07, 32'hFFFFF801, 1'b0);
      run_vec("b_neg", 3'b010, 32'h80000080, 8'h08, 32'hFFFFF800, 1'b0);
      run_vec("j_neg", 3'b100, 32'hFFDFF06F, 8'h09, 32'hFFFFFFFC, 1'b0);
      run_vec("z_max", 3'b101, 32'h800F8000, 8'h0A, 32'h0000001F, 1'b0);

      // U-type on both widths
      push_one(3'b011, 32'h123450B7, 8'h0B);
      chk("u32_imm", 64'(ImmExt), 64'(32'h12345000));
      chk("u64_imm", imm_ext64, 64'h0000000012345000);
      pop_one();
      push_one(3'b011, 32'h800000B7, 8'h0C);
      chk("u32_neg", 64'(ImmExt), 64'(32'h80000000));
      chk("u64_neg", imm_ext64, 64'hFFFFFFFF80000000);
      chk("i64_chk_tag", 64'(out_tag64), 64'(8'h0C));
      pop_one();

      // Compressed codes
`ifdef IMM_EXTEND_RVC_EN
      run_vec("cj_m2", 3'b111, 32'h00001FFC, 8'h0D, 32'hFFFFFFFE, 1'b0);
      run_vec("ci_m1", 3'b110, 32'h00001FFC, 8'h0E, 32'hFFFFFFFF, 1'b0);
`else
      run_vec("cj_off", 3'b111, 32'h00001FFC, 8'h0D, 32'h00000000, 1'b1);
      run_vec("ci_off", 3'b110, 32'h00001FFC, 8'h0E, 32'h00000000, 1'b1);
`endif

      // Backpressure: tags 1..3 with DEPTH=2
      ImmSrc  = 3'b000;
      Instr   = 32'h00100000;
      InTag   = 8'd1;
      InValid = 1'b1;
      step();
      chk("bp_ready1", 64'(InReady), 64'(1'b1));
      InTag = 8'd2;
      step();
      chk("bp_full", 64'(InReady), 64'(1'b0));
      InTag = 8'd3;
      step();
      chk("bp_stall_ready", 64'(InReady), 64'(1'b0));
      chk("bp_head1", 64'(OutTag), 64'(8'd1));
      OutReady = 1'b1;
      step();
      chk("bp_head2", 64'(OutTag), 64'(8'd2));
      chk("bp_ready_after_pop", 64'(InReady), 64'(1'b1));
      step();
      InValid = 1'b0;
      chk("bp_head3", 64'(OutTag), 64'(8'd3));
      chk("bp_head3_valid", 64'(OutValid), 64'(1'b1));
      chk("bp_head3_imm", 64'(ImmExt), 64'(32'h00000001));
      step();
      OutReady = 1'b0;
      chk("bp_drained", 64'(OutValid), 64'(1'b0));

      // Flush with concurrent push
      push_one(3'b000, 32'h00A00000, 8'd10);
      push_one(3'b000, 32'h00B00000, 8'd11);
      chk("fl_full", 64'(InReady), 64'(1'b0));
      Flush   = 1'b1;
      InValid = 1'b1;
      InTag   = 8'd12;
      step();
      Flush   = 1'b0;
      InValid = 1'b0;
      chk("fl_outvalid", 64'(OutValid), 64'(1'b0));
      chk("fl_inready",  64'(InReady),  64'(1'b1));
      chk("fl_imm",      64'(ImmExt),   64'(32'h0));
      step();
      chk("fl_no_ghost", 64'(OutValid), 64'(1'b0));
      run_vec("fl_next", 3'b000, 32'h00D00000, 8'd13, 32'h0000000D, 1'b0);

      // Asynchronous reset mid-stream
      push_one(3'b000, 32'h01400000, 8'd20);
      push_one(3'b000, 32'h01500000, 8'd21);
      chk("ar_pre_valid", 64'(OutValid), 64'(1'b1));
      #2 reset = 1'b1;
      #1;
      chk("ar_outvalid", 64'(OutValid), 64'(1'b0));
      chk("ar_imm",      64'(ImmExt),   64'(32'h0));
      chk("ar_tag",      64'(OutTag),   64'(8'h0));
      step();
      reset = 1'b0;
      #1;
      chk("ar_inready", 64'(InReady), 64'(1'b1));
      step();
      run_vec("ar_post", 3'b000, 32'h01600000, 8'd22, 32'h00000016, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
